hybridcache_ctrl: RTL and testbench
===================================

Name: hybridcache_ctrl

Overview:
- Replacement controller and memory-port arbiter for a bank of NUMLINES hybrid-cache lines that share one dcache read port, one dcache write port and one icache read port.
- Keeps its own region-tag table and detects misses per requester.
- Picks a victim line by lowest hit counter, then drives that line's fill or flush+fill command and grants it the single memory port.
- Also sequences a full-cache flush on request.

Parameters:
- NUMLINES, 4, number of cache lines managed (2..16).
- ADDRBITS, 32, address width.
- LSBBITS, 7, line offset bits (line = 2**LSBBITS bytes).
- MAXHITBITS, 8, width of each line's hit counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- dcache_rdreq / dcache_wrreq / icache_rdreq  in  1 each  requester strobes (same as seen by lines)
- dcache_rdaddr / dcache_wraddr / icache_rdaddr  in  ADDRBITS each  requester addresses
- line_hitcnt  in  NUMLINES*MAXHITBITS  packed hit counters, line i at [i*MAXHITBITS +: MAXHITBITS]
- line_dirty  in  NUMLINES  per-line dirty flags
- line_ready  in  NUMLINES  per-line ready flags
- line_fill  out  NUMLINES  one-hot fill command, 1-cycle pulse
- line_flush  out  NUMLINES  one-hot flush command, 1-cycle pulse
- new_region  out  ADDRBITS  region for fill; low LSBBITS bits are always 0
- mem_grant  out  NUMLINES  one-hot owner of the memory port; 0 = none
- flush_all_req  in  1  request to write back and invalidate every line
- flush_all_done  out  1  1-cycle pulse when a flush-all completes
- ctrl_busy  out  1  high in every state except IDLE
- miss_cnt  out  32  miss counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; tag table invalid; state IDLE.
- Tag table: r_region[i] holds addr[ADDRBITS-1:LSBBITS]; r_valid[i] is set on fill issue and cleared on flush-only issue.
- Per-requester hit: strobe high, and some valid line's tag equals the address tag.
- Miss priority when several requesters miss: dcache read, then dcache write, then icache read.
- Victim selection (combinational): valid=0 lines first, lowest index. Otherwise the lowest line_hitcnt; ties go to the lowest index.
- Command on victim: dirty & valid -> flush and fill both pulsed (flush then fill); otherwise fill only.
- States:
  - IDLE: if flush_all_req, clear index and go FA_SCAN. Otherwise, if any miss and all line_ready=1, latch the miss tag and victim, go ISSUE. flush_all_req has priority over a miss in the same cycle.
  - ISSUE (1 cycle): pulse the command; new_region = {tag, zeros}; mem_grant[victim]=1; update the tag table; go WAIT_BUSY.
  - WAIT_BUSY: hold mem_grant until line_ready[victim]=0, then go WAIT_DONE.
  - WAIT_DONE: hold mem_grant until line_ready[victim]=1, then clear mem_grant and go IDLE.
  - FA_SCAN: if line idx is valid & dirty, pulse line_flush[idx] with mem_grant[idx], clear r_valid[idx], go FA_WAIT. Otherwise, if valid & clean, clear r_valid[idx] with no command. If idx==NUMLINES-1, pulse flush_all_done and go IDLE; else idx++.
  - FA_WAIT: wait for line_ready[idx] to go 0 then 1, clear the grant, return to FA_SCAN at idx+1. When idx==NUMLINES-1, finish as above.
- Latency: a miss seen in IDLE reaches the command pulse at cycle +1.
- At most one line owns the memory port; mem_grant never changes mid-transfer.
- A requester whose hit appears during WAIT states causes no action; misses are re-evaluated only in IDLE.
- Reset mid-operation: all state and the tag table clear immediately; commands drop.

Optional Feature:
- Macro HYBRIDCACHE_CTRL_MISSCNT_EN.
- Defined: miss_cnt increments by 1 on each ISSUE entry and saturates at 32'hFFFF_FFFF; it clears only on reset.
- Undefined: miss_cnt is tied to 0 and no counter register is built.

Test Plan:
- Reset, then dcache_rdreq with addr 0x0000_1000 -> ISSUE next cycle; line_fill=4'b0001, new_region=0x0000_1000, mem_grant=4'b0001. The same address afterwards causes no command.
- Fill all 4 lines; set hitcnts {0x10,0x03,0x03,0xFF}, line 1 dirty; miss at 0x0000_8000 -> line_flush=line_fill=4'b0010 in the same pulse.
- dcache_rdreq miss 0x2000 and icache_rdreq miss 0x3000 in the same cycle -> 0x2000 serviced first; 0x3000 is issued after line_ready returns high.
- flush_all_req with lines 0 and 2 dirty -> flush pulses on line 0 then line 2, each gated by a ready low/high; flush_all_done pulses once; all tags invalid.
- Assert reset_n low during WAIT_DONE -> mem_grant=0, state IDLE, miss_cnt=0 the next cycle.
- With the macro defined, 5 misses -> miss_cnt=5; with it undefined -> miss_cnt=0.

Source files
------------

// File: rtl/hybridcache_ctrl.sv
// Replacement controller and single memory-port arbiter for a bank of hybrid-cache lines.
// Optional miss counter is built only when HYBRIDCACHE_CTRL_MISSCNT_EN is defined.
module hybridcache_ctrl #(
  parameter int NUMLINES   = 4,
  parameter int ADDRBITS   = 32,
  parameter int LSBBITS    = 7,
  parameter int MAXHITBITS = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           dcache_rdreq,
  input  logic                           dcache_wrreq,
  input  logic                           icache_rdreq,
  input  logic [ADDRBITS-1:0]            dcache_rdaddr,
  input  logic [ADDRBITS-1:0]            dcache_wraddr,
  input  logic [ADDRBITS-1:0]            icache_rdaddr,
  input  logic [NUMLINES*MAXHITBITS-1:0] line_hitcnt,
  input  logic [NUMLINES-1:0]            line_dirty,
  input  logic [NUMLINES-1:0]            line_ready,
  output logic [NUMLINES-1:0]            line_fill,
  output logic [NUMLINES-1:0]            line_flush,
  output logic [ADDRBITS-1:0]            new_region,
  output logic [NUMLINES-1:0]            mem_grant,
  input  logic                           flush_all_req,
  output logic                           flush_all_done,
  output logic                           ctrl_busy,
  output logic [31:0]                    miss_cnt
);

  localparam int TAGW = ADDRBITS - LSBBITS;
  localparam int IDXW = $clog2(NUMLINES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMLINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_FA_SCAN, S_FA_WAIT_BUSY, S_FA_WAIT_DONE
  } state_t;

  state_t              state, nxt_state;
  logic [NUMLINES-1:0] r_valid;
  logic [TAGW-1:0]     r_region [NUMLINES];
  logic [TAGW-1:0]     r_tag;
  logic [IDXW-1:0]     r_victim, r_idx;

  logic [TAGW-1:0] dr_tag, dw_tag, ir_tag, miss_tag;
  logic            dr_hit, dw_hit, ir_hit, dr_miss, dw_miss, ir_miss, any_miss, start_issue;
  logic            unused_lsb;

  assign dr_tag     = dcache_rdaddr[ADDRBITS-1:LSBBITS];
  assign dw_tag     = dcache_wraddr[ADDRBITS-1:LSBBITS];
  assign ir_tag     = icache_rdaddr[ADDRBITS-1:LSBBITS];
  assign unused_lsb = ^{dcache_rdaddr[LSBBITS-1:0], dcache_wraddr[LSBBITS-1:0],
                        icache_rdaddr[LSBBITS-1:0]};

  always_comb begin
    dr_hit = 1'b0;
    dw_hit = 1'b0;
    ir_hit = 1'b0;
    for (int i = 0; i < NUMLINES; i++) begin
      if (r_valid[i] && r_region[i] == dr_tag) dr_hit = 1'b1;
      if (r_valid[i] && r_region[i] == dw_tag) dw_hit = 1'b1;
      if (r_valid[i] && r_region[i] == ir_tag) ir_hit = 1'b1;
    end
  end

  assign dr_miss     = dcache_rdreq & ~dr_hit;
  assign dw_miss     = dcache_wrreq & ~dw_hit;
  assign ir_miss     = icache_rdreq & ~ir_hit;
  assign any_miss    = dr_miss | dw_miss | ir_miss;
  assign miss_tag    = dr_miss ? dr_tag : (dw_miss ? dw_tag : ir_tag);
  assign start_issue = any_miss & (&line_ready);

  // Victim: lowest-index invalid line, else lowest hit count with ties to the lowest index.
  logic [IDXW-1:0]       victim, inv_idx, min_idx;
  logic                  found_inv;
  logic [MAXHITBITS-1:0] min_cnt;

  always_comb begin
    found_inv = 1'b0;
    inv_idx   = '0;
    min_idx   = '0;
    min_cnt   = line_hitcnt[0 +: MAXHITBITS];
    for (int i = NUMLINES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        found_inv = 1'b1;
        inv_idx   = IDXW'(i);
      end
    end
    for (int i = 1; i < NUMLINES; i++) begin
      if (line_hitcnt[i*MAXHITBITS +: MAXHITBITS] < min_cnt) begin
        min_cnt = line_hitcnt[i*MAXHITBITS +: MAXHITBITS];
        min_idx = IDXW'(i);
      end
    end
    victim = found_inv ? inv_idx : min_idx;
  end

  logic [NUMLINES-1:0] vic_oh, idx_oh;
  logic                idx_last, idx_dirty;

  assign vic_oh    = {{(NUMLINES-1){1'b0}}, 1'b1} << r_victim;
  assign idx_oh    = {{(NUMLINES-1){1'b0}}, 1'b1} << r_idx;
  assign idx_last  = (r_idx == LAST_IDX);
  assign idx_dirty = r_valid[r_idx] & line_dirty[r_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state      = state;
    line_fill      = '0;
    line_flush     = '0;
    mem_grant      = '0;
    new_region     = '0;
    flush_all_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_all_req)    nxt_state = S_FA_SCAN;
        else if (start_issue) nxt_state = S_ISSUE;
      end
      S_ISSUE: begin
        line_fill  = vic_oh;
        line_flush = (r_valid[r_victim] & line_dirty[r_victim]) ? vic_oh : '0;
        mem_grant  = vic_oh;
        new_region = {r_tag, {LSBBITS{1'b0}}};
        nxt_state  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        mem_grant = vic_oh;
        if (!line_ready[r_victim]) nxt_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        mem_grant = vic_oh;
        if (line_ready[r_victim]) nxt_state = S_IDLE;
      end
      S_FA_SCAN: begin
        if (idx_dirty) begin
          line_flush = idx_oh;
          mem_grant  = idx_oh;
          nxt_state  = S_FA_WAIT_BUSY;
        end else if (idx_last) begin
          flush_all_done = 1'b1;
          nxt_state      = S_IDLE;
        end
      end
      S_FA_WAIT_BUSY: begin
        mem_grant = idx_oh;
        if (!line_ready[r_idx]) nxt_state = S_FA_WAIT_DONE;
      end
      S_FA_WAIT_DONE: begin
        mem_grant = idx_oh;
        if (line_ready[r_idx]) begin
          flush_all_done = idx_last;
          nxt_state      = idx_last ? S_IDLE : S_FA_SCAN;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign ctrl_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= '0;
      r_victim <= '0;
      r_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_all_req)    r_idx    <= '0;
          else if (start_issue) r_victim <= victim;
        end
        S_ISSUE: r_valid[r_victim] <= 1'b1;
        S_FA_SCAN: begin
          r_valid[r_idx] <= 1'b0;
          if (!idx_dirty && !idx_last) r_idx <= r_idx + 1'b1;
        end
        S_FA_WAIT_DONE: begin
          if (line_ready[r_idx] && !idx_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag storage is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && !flush_all_req && start_issue) r_tag <= miss_tag;
    if (state == S_ISSUE) r_region[r_victim] <= r_tag;
  end

`ifdef HYBRIDCACHE_CTRL_MISSCNT_EN
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_miss_cnt <= '0;
    end else if (state == S_IDLE && nxt_state == S_ISSUE && r_miss_cnt != 32'hFFFF_FFFF) begin
      r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign miss_cnt = r_miss_cnt;
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_hybridcache_ctrl.sv
// Self-checking bench for hybridcache_ctrl: behavioural tag/victim model plus a line-ready handshake emulator.
module tb_hybridcache_ctrl;
  localparam int N  = 4;
  localparam int AB = 32;
  localparam int LB = 7;
  localparam int HB = 8;

  logic            clk = 1'b0, reset_n = 1'b0;
  logic            dcache_rdreq = 1'b0, dcache_wrreq = 1'b0, icache_rdreq = 1'b0;
  logic [AB-1:0]   dcache_rdaddr = '0, dcache_wraddr = '0, icache_rdaddr = '0;
  logic [N*HB-1:0] line_hitcnt = '0;
  logic [N-1:0]    line_dirty = '0, line_ready = '1;
  logic [N-1:0]    line_fill, line_flush, mem_grant;
  logic [AB-1:0]   new_region;
  logic            flush_all_req = 1'b0, flush_all_done, ctrl_busy;
  logic [31:0]     miss_cnt;

  int checks = 0, errors = 0;

  bit            m_valid [N];
  logic [AB-LB-1:0] m_tag [N];
  int            m_misses = 0;

  hybridcache_ctrl #(.NUMLINES(N), .ADDRBITS(AB), .LSBBITS(LB), .MAXHITBITS(HB)) dut (
    .clk(clk), .reset_n(reset_n),
    .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq), .icache_rdreq(icache_rdreq),
    .dcache_rdaddr(dcache_rdaddr), .dcache_wraddr(dcache_wraddr), .icache_rdaddr(icache_rdaddr),
    .line_hitcnt(line_hitcnt), .line_dirty(line_dirty), .line_ready(line_ready),
    .line_fill(line_fill), .line_flush(line_flush), .new_region(new_region),
    .mem_grant(mem_grant), .flush_all_req(flush_all_req), .flush_all_done(flush_all_done),
    .ctrl_busy(ctrl_busy), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [AB-1:0] a);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == a[AB-1:LB]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_victim();
    int best = 0;
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    for (int i = 1; i < N; i++)
      if (line_hitcnt[i*HB +: HB] < line_hitcnt[best*HB +: HB]) best = i;
    return best;
  endfunction

  function automatic int exp_miss_cnt();
`ifdef HYBRIDCACHE_CTRL_MISSCNT_EN
    return m_misses;
`else
    return 0;
`endif
  endfunction

  // Entered at the negedge of the ISSUE cycle; returns at the negedge of the following IDLE cycle.
  task automatic issue_and_service(input logic [AB-1:0] a, input string nm);
    int v;
    logic [N-1:0] oh, fl_exp;
    logic [AB-1:0] reg_exp;
    v = model_victim();
    oh = '0;
    oh[v] = 1'b1;
    fl_exp = (m_valid[v] && line_dirty[v]) ? oh : '0;
    reg_exp = {a[AB-1:LB], {LB{1'b0}}};
    m_valid[v] = 1'b1;
    m_tag[v] = a[AB-1:LB];
    m_misses++;
    checks++;
    if ({line_fill, line_flush, mem_grant, new_region, ctrl_busy} !== {oh, fl_exp, oh, reg_exp, 1'b1}) begin
      errors++;
      $display("FAIL %s_issue: fill=%b flush=%b grant=%b region=%h busy=%b, expected fill=%b flush=%b grant=%b region=%h busy=1",
               nm, line_fill, line_flush, mem_grant, new_region, ctrl_busy, oh, fl_exp, oh, reg_exp);
    end
    @(negedge clk);
    checks++;
    if ({line_fill, line_flush, mem_grant} !== {{N{1'b0}}, {N{1'b0}}, oh}) begin
      errors++;
      $display("FAIL %s_wait_busy: fill=%b flush=%b grant=%b, expected fill=0 flush=0 grant=%b",
               nm, line_fill, line_flush, mem_grant, oh);
    end
    line_ready[v] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_grant !== oh) begin
      errors++;
      $display("FAIL %s_wait_done: grant=%b expected %b", nm, mem_grant, oh);
    end
    line_ready[v] = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_grant !== '0 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: grant=%b busy=%b expected grant=0 busy=0", nm, mem_grant, ctrl_busy);
    end
    line_dirty[v] = 1'b0;
  endtask

  // Entered at a negedge in IDLE; strobes are held for exactly one clock edge.
  task automatic request(input logic [2:0] s, input logic [AB-1:0] a0, a1, a2, input string nm);
    logic [AB-1:0] addrs [3];
    int win;
    addrs = '{a0, a1, a2};
    win = -1;
    for (int r = 0; r < 3; r++) if (win < 0 && s[r] && !model_hit(addrs[r])) win = r;
    dcache_rdreq = s[0]; dcache_rdaddr = a0;
    dcache_wrreq = s[1]; dcache_wraddr = a1;
    icache_rdreq = s[2]; icache_rdaddr = a2;
    @(negedge clk);
    dcache_rdreq = 1'b0; dcache_wrreq = 1'b0; icache_rdreq = 1'b0;
    if (win < 0) begin
      checks++;
      if (ctrl_busy !== 1'b0 || line_fill !== '0) begin
        errors++;
        $display("FAIL %s_no_action: busy=%b fill=%b expected busy=0 fill=0", nm, ctrl_busy, line_fill);
      end
    end else begin
      issue_and_service(addrs[win], nm);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({line_fill, line_flush, new_region, mem_grant, flush_all_done, ctrl_busy, miss_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: fill=%b flush=%b region=%h grant=%b done=%b busy=%b cnt=%0d expected all 0",
               line_fill, line_flush, new_region, mem_grant, flush_all_done, ctrl_busy, miss_cnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_fill();
    request(3'b001, 32'h0000_1000, '0, '0, "basic");
    request(3'b001, 32'h0000_1050, '0, '0, "basic_hit");
    request(3'b010, '0, 32'h0000_107F, '0, "basic_wr_hit");
  endtask

  task automatic test_victim_flush();
    line_hitcnt = {8'hFF, 8'h03, 8'h03, 8'h10};
    request(3'b010, '0, 32'h0000_4000, '0, "fill1");
    request(3'b100, '0, '0, 32'h0000_5000, "fill2");
    request(3'b001, 32'h0000_6000, '0, '0, "fill3");
    line_dirty = 4'b0010;
    request(3'b001, 32'h0000_8000, '0, '0, "victim_flush");
  endtask

  task automatic test_priority();
    dcache_rdreq = 1'b1; dcache_rdaddr = 32'h0000_2000;
    icache_rdreq = 1'b1; icache_rdaddr = 32'h0000_3000;
    @(negedge clk);
    issue_and_service(32'h0000_2000, "prio_first");
    @(negedge clk);
    dcache_rdreq = 1'b0; icache_rdreq = 1'b0;
    issue_and_service(32'h0000_3000, "prio_second");
  endtask

  task automatic test_random();
    logic [AB-1:0] a [3];
    for (int it = 0; it < 30; it++) begin
      line_hitcnt = $urandom;
      line_dirty = 4'($urandom);
      for (int r = 0; r < 3; r++)
        a[r] = {25'h40 + 25'($urandom_range(0, 7)), 7'($urandom)};
      request(3'($urandom_range(0, 7)), a[0], a[1], a[2], "rand");
    end
  endtask

  task automatic test_misscnt(input string nm);
    checks++;
    if (miss_cnt !== 32'(exp_miss_cnt())) begin
      errors++;
      $display("FAIL %s_miss_cnt: got %0d expected %0d", nm, miss_cnt, exp_miss_cnt());
    end
  endtask

  task automatic test_flush_all();
    logic [N-1:0] oh;
    bool_dummy: begin end
    line_dirty = 4'b0101;
    flush_all_req = 1'b1;
    dcache_rdreq = 1'b1; dcache_rdaddr = 32'h7F00_0000;
    @(negedge clk);
    flush_all_req = 1'b0; dcache_rdreq = 1'b0;
    checks++;
    if (line_fill !== '0 || ctrl_busy !== 1'b1) begin
      errors++;
      $display("FAIL fa_priority: fill=%b busy=%b expected fill=0 busy=1", line_fill, ctrl_busy);
    end
    for (int idx = 0; idx < N; idx++) begin
      oh = '0;
      oh[idx] = 1'b1;
      if (m_valid[idx] && line_dirty[idx]) begin
        checks++;
        if ({line_flush, mem_grant, line_fill, flush_all_done} !== {oh, oh, {N{1'b0}}, 1'b0}) begin
          errors++;
          $display("FAIL fa_flush%0d: flush=%b grant=%b fill=%b done=%b expected flush=%b grant=%b fill=0 done=0",
                   idx, line_flush, mem_grant, line_fill, flush_all_done, oh, oh);
        end
        m_valid[idx] = 1'b0;
        @(negedge clk);
        line_ready[idx] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_grant !== oh || flush_all_done !== 1'b0) begin
          errors++;
          $display("FAIL fa_hold%0d: grant=%b done=%b expected grant=%b done=0", idx, mem_grant, flush_all_done, oh);
        end
        line_ready[idx] = 1'b1;
        #1;
        checks++;
        if (flush_all_done !== (idx == N - 1)) begin
          errors++;
          $display("FAIL fa_done_after_wait%0d: done=%b expected %b", idx, flush_all_done, idx == N - 1);
        end
        line_dirty[idx] = 1'b0;
      end else begin
        m_valid[idx] = 1'b0;
        checks++;
        if ({line_flush, mem_grant, flush_all_done} !== {{N{1'b0}}, {N{1'b0}}, idx == N - 1}) begin
          errors++;
          $display("FAIL fa_skip%0d: flush=%b grant=%b done=%b expected flush=0 grant=0 done=%b",
                   idx, line_flush, mem_grant, flush_all_done, idx == N - 1);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ctrl_busy !== 1'b0 || flush_all_done !== 1'b0) begin
      errors++;
      $display("FAIL fa_end: busy=%b done=%b expected busy=0 done=0", ctrl_busy, flush_all_done);
    end
    request(3'b001, 32'h0000_2000, '0, '0, "fa_tags_cleared");
  endtask

  task automatic test_reset_mid();
    int v;
    v = model_victim();
    dcache_rdreq = 1'b1; dcache_rdaddr = 32'h0ABC_0000;
    @(negedge clk);
    dcache_rdreq = 1'b0;
    @(negedge clk);
    line_ready[v] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_grant !== '0 || ctrl_busy !== 1'b0 || miss_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: grant=%b busy=%b cnt=%0d expected 0 0 0", mem_grant, ctrl_busy, miss_cnt);
    end
    @(negedge clk);
    checks++;
    if ({mem_grant, line_fill, line_flush, ctrl_busy, flush_all_done, miss_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid_hold: grant=%b fill=%b flush=%b busy=%b done=%b cnt=%0d expected all 0",
               mem_grant, line_fill, line_flush, ctrl_busy, flush_all_done, miss_cnt);
    end
    line_ready = '1;
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_misses = 0;
    @(negedge clk);
    request(3'b001, 32'h0000_2000, '0, '0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_victim_flush();
    test_priority();
    test_random();
    test_misscnt("mid");
    test_flush_all();
    test_reset_mid();
    test_misscnt("end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
